// File: rtl/wirein_cmd_pkg.sv
// Shared opcodes, FSM states and status-word bit positions for the
// FrontPanel wire-in command responder.
package wirein_cmd_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL,
    CLR,
    DONE
  } state_t;

  localparam int ST_ACK    = 31;
  localparam int ST_BUSY   = 30;
  localparam int ST_ERR    = 29;
  localparam int ST_OP_LSB = 26;

endpackage

// File: rtl/wirein_cmd_responder_mul.sv
// Iterative 32x32 -> low-32 shift-add multiplier. The start edge performs the
// first partial product, so done pulses exactly 32 cycles after start.
module seq_mul32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] p
);

  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [4:0]  iter_q;
  logic        run_q;
  logic        done_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc_q    <= b[0] ? a : '0;
        mcand_q  <= a << 1;
        mplier_q <= b >> 1;
        iter_q   <= 5'd1;
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        iter_q   <= iter_q + 5'd1;
        // Iteration 31 consumes the last multiplier bit.
        if (iter_q == 5'd31) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/wirein_cmd_responder.sv
// Host command responder: executes commands posted via two Wire Ins against a
// small register file and reports result plus an ack toggle via two Wire Outs.
module wirein_cmd_responder
  import wirein_cmd_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int CNT_W = 16
) (
  input  logic        okClk,
  input  logic        reset_n,
  input  logic [31:0] cmd_wire,
  input  logic [31:0] data_wire,
  output logic [31:0] status_wire,
  output logic [31:0] result_wire
);

  localparam int IW = $clog2(NREGS);

  state_t state_q;
  state_t state_next;

  logic             req_q;
  logic [2:0]       cmd_op_q;
  logic [IW-1:0]    cmd_idx_q;
  logic [31:0]      data_q;

  logic [2:0]       op_q;
  logic [IW-1:0]    idx_q;
  logic [31:0]      opnd_q;

  logic             ack_q;
  logic             busy_q;
  logic             err_q;
  logic [2:0]       last_op_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      res_q;
  logic [31:0]      result_q;
  logic [IW-1:0]    clr_idx_q;

  logic [NREGS-1:0][31:0] regs_q;
  logic [NREGS-1:0][31:0] regs_next;

  logic        accept;
  logic        mul_start;
  logic        clr_en;
  logic        finish;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [31:0] exec_res;
  logic        mul_done;
  logic [31:0] mul_p;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_wire[27:IW];

  always_ff @(posedge okClk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      IDLE: if (req_q != ack_q) state_next = EXEC;
      EXEC: begin
        if (op_q == OP_MUL) begin
          state_next = MUL;
        end else if (op_q == OP_CLEAR) begin
          state_next = CLR;
        end else begin
          state_next = DONE;
        end
      end
      MUL:  if (mul_done) state_next = DONE;
      CLR:  if (clr_idx_q == IW'(NREGS - 1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    mul_start = 1'b0;
    clr_en    = 1'b0;
    finish    = 1'b0;
    wr_en     = 1'b0;
    rd_data   = regs_q[idx_q];
    wr_data   = opnd_q;
    exec_res  = result_q;
    unique case (state_q)
      IDLE: accept = (req_q != ack_q);
      EXEC: begin
        unique case (op_q)
          OP_WRITE: begin
            wr_en    = 1'b1;
            wr_data  = opnd_q;
            exec_res = opnd_q;
          end
          OP_READ:  exec_res = rd_data;
          OP_ADD: begin
            wr_en    = 1'b1;
            wr_data  = rd_data + opnd_q;
            exec_res = rd_data + opnd_q;
          end
          OP_SUB: begin
            wr_en    = 1'b1;
            wr_data  = rd_data - opnd_q;
            exec_res = rd_data - opnd_q;
          end
          OP_MUL:   mul_start = 1'b1;
          OP_CLEAR: exec_res = '0;
          default:  exec_res = result_q;
        endcase
      end
      CLR:  clr_en = 1'b1;
      DONE: finish = 1'b1;
      default: ;
    endcase
  end

  // Per-register next value: a clear sweep and a single-index write never overlap.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
    assign regs_next[gi] = (clr_en && clr_idx_q == IW'(gi)) ? 32'd0 :
                           (wr_en && idx_q == IW'(gi))      ? wr_data :
                                                              regs_q[gi];
  end

  always_ff @(posedge okClk) begin
    if (!reset_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_next;
    end
  end

  always_ff @(posedge okClk) begin
    if (!reset_n) begin
      req_q     <= 1'b0;
      cmd_op_q  <= '0;
      cmd_idx_q <= '0;
      data_q    <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      opnd_q    <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      last_op_q <= '0;
      count_q   <= '0;
      res_q     <= '0;
      result_q  <= '0;
      clr_idx_q <= '0;
    end else begin
      req_q     <= cmd_wire[31];
      cmd_op_q  <= cmd_wire[30:28];
      cmd_idx_q <= cmd_wire[IW-1:0];
      data_q    <= data_wire;
      if (accept) begin
        op_q   <= cmd_op_q;
        idx_q  <= cmd_idx_q;
        opnd_q <= data_q;
        busy_q <= 1'b1;
      end
      if (state_q == EXEC) begin
        res_q     <= exec_res;
        clr_idx_q <= '0;
      end
      if (clr_en) begin
        clr_idx_q <= clr_idx_q + IW'(1);
      end
      // All host-visible completion fields move together on this one edge.
      if (finish) begin
        result_q  <= (op_q == OP_MUL) ? mul_p : res_q;
        err_q     <= (op_q == OP_RSVD);
        last_op_q <= op_q;
        count_q   <= count_q + CNT_W'(1);
        ack_q     <= ~ack_q;
        busy_q    <= 1'b0;
      end
    end
  end

  seq_mul32 u_mul (
    .clk     (okClk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (rd_data),
    .b       (opnd_q),
    .done    (mul_done),
    .p       (mul_p)
  );

  always_comb begin
    status_wire                           = '0;
    status_wire[ST_ACK]                   = ack_q;
    status_wire[ST_BUSY]                  = busy_q;
    status_wire[ST_ERR]                   = err_q;
    status_wire[ST_OP_LSB+2:ST_OP_LSB]    = last_op_q;
    status_wire[CNT_W-1:0]                = count_q;
  end

  assign result_wire = result_q;

endmodule
